// File: rtl/display_scheduler.sv
// Four-digit seven-segment scheduler: per-slot dead-time blanking, PWM brightness,
// per-digit masking and whole-display flash. Define HEX_DECODE_EN to show codes 10-15 as hex.
module display_scheduler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int FLASH_DIV    = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] thousands_i,
  input  logic [3:0] hundreds_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic [3:0] blank_mask_i,
  input  logic [2:0] brightness_i,
  input  logic       flash_req_i,
  input  logic       colon_en_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(FLASH_DIV);
  localparam int D8 = (REFRESH_DIV - BLANK_CYCLES) / 8;

  typedef enum logic {BLANK, DRIVE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          mask_q, mask_d;
  logic [2:0]    bright_q, bright_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          flashOff_q, flashOff_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          slotWrap, slotStart;
  logic [3:0]    selDigit;
  logic [31:0]   kD, thr;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'h40;
      4'd1:    decode7 = 7'h79;
      4'd2:    decode7 = 7'h24;
      4'd3:    decode7 = 7'h30;
      4'd4:    decode7 = 7'h19;
      4'd5:    decode7 = 7'h12;
      4'd6:    decode7 = 7'h02;
      4'd7:    decode7 = 7'h78;
      4'd8:    decode7 = 7'h00;
      4'd9:    decode7 = 7'h10;
`ifdef HEX_DECODE_EN
      4'd10:   decode7 = 7'h08;
      4'd11:   decode7 = 7'h03;
      4'd12:   decode7 = 7'h46;
      4'd13:   decode7 = 7'h21;
      4'd14:   decode7 = 7'h06;
      4'd15:   decode7 = 7'h0E;
`endif
      default: decode7 = 7'h7F;
    endcase
  endfunction

  // Slot timing, digit index, per-slot captured controls and flash timer.
  always_comb begin
    slotWrap  = (cnt_q == CW'(REFRESH_DIV - 1));
    slotStart = (cnt_q == '0);
    cnt_d     = slotWrap ? '0 : cnt_q + CW'(1);
    idx_d     = slotWrap ? idx_q + 2'd1 : idx_q;
    mask_d    = slotStart ? blank_mask_i[idx_q] : mask_q;
    bright_d  = slotStart ? brightness_i : bright_q;
    fcnt_d    = '0;
    flashOff_d = 1'b0;
    if (flash_req_i) begin
      if (fcnt_q == FW'(FLASH_DIV - 1)) begin
        fcnt_d     = '0;
        flashOff_d = ~flashOff_q;
      end else begin
        fcnt_d     = fcnt_q + FW'(1);
        flashOff_d = flashOff_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      mask_q     <= 1'b0;
      bright_q   <= '0;
      fcnt_q     <= '0;
      flashOff_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      bright_q   <= bright_d;
      fcnt_q     <= fcnt_d;
      flashOff_q <= flashOff_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BLANK;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_d == CW'(BLANK_CYCLES)) state_d = DRIVE;
      DRIVE:   if (slotWrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Outputs are computed for the next counter value so the pins line up with it.
  always_comb begin
    case (idx_q)
      2'd0:    selDigit = ones_i;
      2'd1:    selDigit = tens_i;
      2'd2:    selDigit = hundreds_i;
      default: selDigit = thousands_i;
    endcase
    seg_d = seg_q;
    dp_d  = dp_q;
    if (slotStart) begin
      seg_d = decode7(selDigit);
      dp_d  = ~((idx_q == 2'd2) && colon_en_i);
    end
    kD   = 32'(cnt_d) - 32'(BLANK_CYCLES);
    thr  = (32'(bright_d) + 32'd1) * 32'(D8);
    an_d = 4'hF;
    if (state_d == DRIVE && !mask_d && !flashOff_d && kD < thr) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler against a cycle-count reference model.
// Honours HEX_DECODE_EN the same way as the design.
module tb_display_scheduler;

  localparam int RD = 18;
  localparam int BC = 2;
  localparam int FD = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] thousands, hundreds, tens, ones, blankMask;
  logic [2:0] brightness;
  logic       flashReq, colonEn;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;

  int         t, fe;
  logic [3:0] mAn;
  logic [6:0] mSeg;
  logic       mDp, mMask;
  logic [2:0] mBright;

  display_scheduler #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .FLASH_DIV(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .thousands_i(thousands), .hundreds_i(hundreds), .tens_i(tens), .ones_i(ones),
    .blank_mask_i(blankMask), .brightness_i(brightness),
    .flash_req_i(flashReq), .colon_en_i(colonEn),
    .an_o(an), .seg_o(seg), .dp_o(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] refDecode(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef HEX_DECODE_EN
            7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
            7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
    return tbl[d];
  endfunction

  function automatic logic [3:0] digitAt(input int i);
    case (i)
      0:       return ones;
      1:       return tens;
      2:       return hundreds;
      default: return thousands;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (time %0t, t=%0d)", tag, obs, exp, $time, t);
    end
  endtask

  task automatic modelReset();
    t = 0; fe = 0;
    mAn = 4'hF; mSeg = 7'h7F; mDp = 1'b1; mMask = 1'b0; mBright = 3'd0;
  endtask

  // One clock edge of the reference: slot = t/RD, position = t%RD, digit = slot%4.
  task automatic modelEdge();
    int c, idx, k;
    if (!rst_n) return;
    c = t % RD;
    if (c == 0) begin
      idx     = (t / RD) % 4;
      mMask   = blankMask[idx];
      mBright = brightness;
      mSeg    = refDecode(digitAt(idx));
      mDp     = !(idx == 2 && colonEn);
    end
    fe = flashReq ? fe + 1 : 0;
    t++;
    c   = t % RD;
    idx = (t / RD) % 4;
    k   = c - BC;
    mAn = 4'hF;
    if (c >= BC && k < (int'(mBright) + 1) * ((RD - BC) / 8) && !mMask && ((fe / FD) % 2 == 0))
      mAn[idx] = 1'b0;
  endtask

  task automatic checkAll();
    checkOutput("an", 32'(an), 32'(mAn));
    checkOutput("seg", 32'(seg), 32'(mSeg));
    checkOutput("dp", 32'(dp), 32'(mDp));
    checkOutput("oneAnode", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic randomInputs();
    thousands  = 4'($urandom_range(0, 15));
    hundreds   = 4'($urandom_range(0, 15));
    tens       = 4'($urandom_range(0, 15));
    ones       = 4'($urandom_range(0, 15));
    blankMask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    brightness = 3'($urandom);
    colonEn    = 1'($urandom);
    if ($urandom_range(0, 3) == 0) flashReq = ~flashReq;
  endtask

  task automatic applyStimulus(input int n, input bit doRandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
      if (doRandom && $urandom_range(0, 9) == 0) randomInputs();
    end
  endtask

  initial begin
    bit found;
    thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; ones = 4'd4;
    blankMask = 4'h0; brightness = 3'd7; flashReq = 1'b0; colonEn = 1'b0;
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    $display("[TB] basic scan, full brightness");
    applyStimulus(80, 0);

    $display("[TB] minimum brightness, then mid-slot change");
    brightness = 3'd0;
    applyStimulus(40, 0);
    found = 0;
    for (int i = 0; i < RD + 1; i++) begin
      if (t % RD == 5) begin found = 1; break; end
      applyStimulus(1, 0);
    end
    checkOutput("reachMidSlot", 32'(found), 32'd1);
    brightness = 3'd3;
    applyStimulus(60, 0);

    $display("[TB] masked hundreds with colon");
    brightness = 3'd7; blankMask = 4'b0100; colonEn = 1'b1;
    applyStimulus(80, 0);

    $display("[TB] all digits masked");
    blankMask = 4'hF;
    applyStimulus(40, 0);

    $display("[TB] flash");
    blankMask = 4'h0; colonEn = 1'b0; flashReq = 1'b1;
    applyStimulus(150, 0);
    flashReq = 1'b0;
    applyStimulus(5, 0);
    flashReq = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * FD; i++) begin
      if (fe == FD + 16 + (RD - (t % RD)) % RD) begin found = 1; break; end
      applyStimulus(1, 0);
    end
    checkOutput("reachFlashOff", 32'(found), 32'd1);
    flashReq = 1'b0;
    applyStimulus(30, 0);

    $display("[TB] hex code on ones");
    ones = 4'hB;
    applyStimulus(80, 0);

    $display("[TB] randomized run");
    applyStimulus(800, 1);

    $display("[TB] reset in tens drive window");
    flashReq = 1'b0; blankMask = 4'h0; brightness = 3'd7;
    found = 0;
    for (int i = 0; i < 6 * RD; i++) begin
      if ((t / RD) % 4 == 1 && t % RD == 8) begin found = 1; break; end
      applyStimulus(1, 0);
    end
    checkOutput("reachTensDrive", 32'(found), 32'd1);
    checkOutput("anLowBeforeReset", 32'(an), 32'hD);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    applyStimulus(3, 0);
    rst_n = 1'b1;
    applyStimulus(80, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
